// File: rtl/fibo_pkg.sv
// Shared types and constants for the Fibonacci job scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fibo_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_B2B,
        ST_FIB,
        ST_B2D,
        ST_RESP
    } sched_state_t;

    localparam int BCD_DIGIT_W = 4;
    localparam int FIB_IDX_MAX = 31;
    localparam int BCD_SAT     = 9999;

    function automatic logic bcd_pair_ok(input logic [2*BCD_DIGIT_W-1:0] v);
        return (v[2*BCD_DIGIT_W-1:BCD_DIGIT_W] <= 4'd9) && (v[BCD_DIGIT_W-1:0] <= 4'd9);
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter; favours the requester not granted last.
// Latency: combinational grant, pointer updates one cycle after adv.
// Backpressure: none; pointer only moves on the adv strobe.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       adv,
    input  logic       adv_id,
    output logic       gnt_vld,
    output logic       gnt_id
);

    logic last_id;

    assign gnt_vld = |req;
    assign gnt_id  = !(req[0] && (last_id || !req[1]));

    // Pointer starts at 1 so requester 0 wins the first contested grant.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_id <= 1'b1;
        end else if (adv) begin
            last_id <= adv_id;
        end
    end

endmodule

// File: rtl/fibo_job_scheduler.sv
// Grants one BCD job at a time and walks it through b2b -> fib -> b2d units.
// Latency: 3 + t_b2b + t_fib + t_b2d cycles from req_ack to rsp_valid.
// Backpressure: requests wait (held valid) until the scheduler returns to IDLE.
module fibo_job_scheduler
    import fibo_pkg::*;
#(
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  req_valid,
    input  logic [7:0]  req_bcd0,
    input  logic [7:0]  req_bcd1,
    output logic [1:0]  req_ack,
    output logic        b2b_start,
    output logic [7:0]  b2b_bcd,
    input  logic        b2b_done,
    input  logic [6:0]  b2b_bin,
    output logic        fib_start,
    output logic [4:0]  fib_idx,
    input  logic        fib_done,
    input  logic [19:0] fib_val,
    output logic        b2d_start,
    output logic [13:0] b2d_bin,
    input  logic        b2d_done,
    input  logic [15:0] b2d_bcd,
    output logic        rsp_valid,
    output logic        rsp_id,
    output logic [15:0] rsp_bcd,
    output logic        rsp_err,
    output logic        busy
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    sched_state_t     state;
    sched_state_t     state_nxt;
    logic [CNT_W-1:0] stage_cnt;
    logic             tmo;
    logic             gnt_vld;
    logic             gnt_id;
    logic [7:0]       gnt_bcd;
    logic             opnd_ok;

    assign tmo     = (stage_cnt == CNT_W'(TIMEOUT_CYC - 1));
    assign gnt_bcd = gnt_id ? req_bcd1 : req_bcd0;
    assign opnd_ok = bcd_pair_ok(gnt_bcd);

    rr_arbiter2 u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req_valid),
        .adv     (state == ST_RESP),
        .adv_id  (rsp_id),
        .gnt_vld (gnt_vld),
        .gnt_id  (gnt_id)
    );

    // A done in the same cycle as the timeout still wins.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (gnt_vld) state_nxt = opnd_ok ? ST_B2B : ST_RESP;
            ST_B2B:  if (b2b_done) state_nxt = ST_FIB;  else if (tmo) state_nxt = ST_RESP;
            ST_FIB:  if (fib_done) state_nxt = ST_B2D;  else if (tmo) state_nxt = ST_RESP;
            ST_B2D:  if (b2d_done) state_nxt = ST_RESP; else if (tmo) state_nxt = ST_RESP;
            ST_RESP: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            stage_cnt <= '0;
            req_ack   <= '0;
            b2b_start <= 1'b0;
            b2b_bcd   <= '0;
            fib_start <= 1'b0;
            fib_idx   <= '0;
            b2d_start <= 1'b0;
            b2d_bin   <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_bcd   <= '0;
            rsp_err   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            stage_cnt <= (state_nxt != state || state == ST_IDLE) ? '0 : stage_cnt + 1'b1;
            busy      <= (state_nxt != ST_IDLE);
            rsp_valid <= (state_nxt == ST_RESP);
            req_ack   <= '0;
            b2b_start <= 1'b0;
            fib_start <= 1'b0;
            b2d_start <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (gnt_vld) begin
                        req_ack   <= gnt_id ? 2'b10 : 2'b01;
                        rsp_id    <= gnt_id;
                        b2b_bcd   <= gnt_bcd;
                        rsp_bcd   <= '0;
                        rsp_err   <= !opnd_ok;
                        b2b_start <= opnd_ok;
                    end
                end
                ST_B2B: begin
                    if (b2b_done) begin
                        fib_start <= 1'b1;
                        fib_idx   <= (b2b_bin > 7'(FIB_IDX_MAX)) ? 5'(FIB_IDX_MAX) : b2b_bin[4:0];
                    end else if (tmo) begin
                        rsp_err <= 1'b1;
                        rsp_bcd <= '0;
                    end
                end
                ST_FIB: begin
                    if (fib_done) begin
                        b2d_start <= 1'b1;
                        b2d_bin   <= (fib_val >= 20'(BCD_SAT)) ? 14'(BCD_SAT) : fib_val[13:0];
                    end else if (tmo) begin
                        rsp_err <= 1'b1;
                        rsp_bcd <= '0;
                    end
                end
                ST_B2D: begin
                    if (b2d_done) begin
                        rsp_bcd <= b2d_bcd;
                        rsp_err <= 1'b0;
                    end else if (tmo) begin
                        rsp_err <= 1'b1;
                        rsp_bcd <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fibo_job_scheduler.sv
// Self-checking bench for fibo_job_scheduler with behavioural compute units.
// Expected responses are queued as jobs are driven and compared on rsp_valid.
module tb_fibo_job_scheduler;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  req_valid;
    logic [7:0]  req_bcd0, req_bcd1;
    logic [1:0]  req_ack;
    logic        b2b_start, b2b_done;
    logic [7:0]  b2b_bcd;
    logic [6:0]  b2b_bin;
    logic        fib_start, fib_done, fib_done_m, fib_late;
    logic [4:0]  fib_idx;
    logic [19:0] fib_val;
    logic        b2d_start, b2d_done, b2d_done_m, b2d_stray;
    logic [13:0] b2d_bin;
    logic [15:0] b2d_bcd;
    logic        rsp_valid, rsp_id, rsp_err, busy;
    logic [15:0] rsp_bcd;

    assign fib_done = fib_done_m | fib_late;
    assign b2d_done = b2d_done_m | b2d_stray;

    always #5 clk = ~clk;

    fibo_job_scheduler #(.TIMEOUT_CYC(16)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_bcd0(req_bcd0), .req_bcd1(req_bcd1),
        .req_ack(req_ack), .b2b_start(b2b_start), .b2b_bcd(b2b_bcd), .b2b_done(b2b_done),
        .b2b_bin(b2b_bin), .fib_start(fib_start), .fib_idx(fib_idx), .fib_done(fib_done),
        .fib_val(fib_val), .b2d_start(b2d_start), .b2d_bin(b2d_bin), .b2d_done(b2d_done),
        .b2d_bcd(b2d_bcd), .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_bcd(rsp_bcd),
        .rsp_err(rsp_err), .busy(busy)
    );

    typedef struct { logic id; logic [15:0] bcd; logic err; } rsp_t;
    typedef struct {
        logic id; logic [7:0] bcd; int tb; int tf; int td;
        logic [15:0] ebcd; logic eerr; int elat; logic [4:0] eidx; logic [13:0] ebin;
    } vec_t;

    rsp_t        exp_q[$];
    int          checks = 0, failures = 0;
    int          t_b2b = 1, t_fib = 1, t_b2d = 1;
    bit          fib_hang = 0;
    int          n_start = 0, cyc = 0, fib_start_cyc = 0;
    logic [4:0]  seen_idx;
    logic [13:0] seen_bin;
    logic        rr_last = 1'b1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic int fib(input int n);
        int a = 0, b = 1, t;
        for (int i = 0; i < n; i++) begin t = a + b; a = b; b = t; end
        return a;
    endfunction

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    initial forever @(posedge clk) cyc++;

    // Behavioural units: done pulses t cycles after start (t=0 means same cycle).
    initial begin : m_b2b
        int cnt; bit pend; int val;
        pend = 0; b2b_done = 0; b2b_bin = '0;
        forever begin
            @(negedge clk);
            b2b_done = 0;
            if (!rst_n) pend = 0;
            else begin
                if (b2b_start) begin
                    pend = 1; cnt = t_b2b;
                    val = int'(b2b_bcd[7:4]) * 10 + int'(b2b_bcd[3:0]);
                end
                if (pend) begin
                    if (cnt == 0) begin b2b_done = 1; b2b_bin = 7'(val); pend = 0; end
                    else cnt--;
                end
            end
        end
    end

    initial begin : m_fib
        int cnt; bit pend; int val;
        pend = 0; fib_done_m = 0; fib_val = '0;
        forever begin
            @(negedge clk);
            fib_done_m = 0;
            if (!rst_n) pend = 0;
            else begin
                if (fib_start && !fib_hang) begin
                    pend = 1; cnt = t_fib;
                    val = fib(int'(fib_idx));
                    if (val > 20'hFFFFF) val = 20'hFFFFF;
                end
                if (pend) begin
                    if (cnt == 0) begin fib_done_m = 1; fib_val = 20'(val); pend = 0; end
                    else cnt--;
                end
            end
        end
    end

    initial begin : m_b2d
        int cnt; bit pend; int val;
        pend = 0; b2d_done_m = 0; b2d_bcd = '0;
        forever begin
            @(negedge clk);
            b2d_done_m = 0;
            if (!rst_n) pend = 0;
            else begin
                if (b2d_start) begin pend = 1; cnt = t_b2d; val = int'(b2d_bin); end
                if (pend) begin
                    if (cnt == 0) begin b2d_done_m = 1; b2d_bcd = to_bcd(val); pend = 0; end
                    else cnt--;
                end
            end
        end
    end

    initial forever begin
        @(negedge clk);
        n_start += int'(b2b_start) + int'(fib_start) + int'(b2d_start);
        if (fib_start) begin seen_idx = fib_idx; fib_start_cyc = cyc; end
        if (b2d_start) seen_bin = b2d_bin;
    end

    // Scoreboard: every response must match the oldest queued expectation.
    initial begin : m_rsp
        rsp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && rsp_valid) begin
                if (exp_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_rsp actual=rsp_valid=1 required=no response");
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_id", rsp_id, e.id);
                    chk("rsp_bcd", rsp_bcd, e.bcd);
                    chk("rsp_err", rsp_err, e.err);
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog actual=still running required=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic push_exp(input logic id, input logic [15:0] bcd, input logic err);
        rsp_t e;
        e.id = id; e.bcd = bcd; e.err = err;
        exp_q.push_back(e);
    endtask

    task automatic wait_ack(input int lim, output bit got);
        got = 0;
        for (int i = 0; i < lim && !got; i++) begin
            @(negedge clk);
            got = (req_ack != 2'b00);
        end
    endtask

    task automatic wait_rsp(input int lim, output int n);
        n = 0;
        while (!rsp_valid && n < lim) begin @(negedge clk); n++; end
    endtask

    task automatic run_job(input logic id, input logic [7:0] bcd, input int tb, input int tf,
                           input int td, input logic [15:0] ebcd, input logic eerr,
                           input int elat, input string tag);
        bit got; int lat, n0;
        t_b2b = tb; t_fib = tf; t_b2d = td;
        push_exp(id, ebcd, eerr);
        @(negedge clk);
        if (id) req_bcd1 = bcd; else req_bcd0 = bcd;
        req_valid[id] = 1'b1;
        n0 = n_start;
        wait_ack(50, got);
        req_valid[id] = 1'b0;
        chk({tag, "_ack"}, req_ack, id ? 2'b10 : 2'b01);
        chk({tag, "_busy"}, busy, 1);
        wait_rsp(2000, lat);
        chk({tag, "_latency"}, lat, elat);
        chk({tag, "_starts"}, n_start - n0, eerr ? 0 : 3);
        rr_last = id;
    endtask

    vec_t vecs[9];

    initial begin
        bit got; int n, gap, n0; logic g;
        req_valid = 2'b00; req_bcd0 = '0; req_bcd1 = '0;
        fib_late = 0; b2d_stray = 0;

        vecs[0] = '{1'b0, 8'h07, 2, 10, 15, 16'h0013, 1'b0, 30, 5'd7,  14'd13};
        vecs[1] = '{1'b1, 8'h20, 1, 1,  1,  16'h6765, 1'b0, 6,  5'd20, 14'd6765};
        vecs[2] = '{1'b0, 8'h25, 0, 0,  0,  16'h9999, 1'b0, 3,  5'd25, 14'd9999};
        vecs[3] = '{1'b1, 8'h00, 3, 0,  2,  16'h0000, 1'b0, 8,  5'd0,  14'd0};
        vecs[4] = '{1'b0, 8'h99, 1, 2,  3,  16'h9999, 1'b0, 9,  5'd31, 14'd9999};
        vecs[5] = '{1'b1, 8'h1A, 1, 1,  1,  16'h0000, 1'b1, 0,  5'd0,  14'd0};
        vecs[6] = '{1'b0, 8'hA0, 1, 1,  1,  16'h0000, 1'b1, 0,  5'd0,  14'd0};
        vecs[7] = '{1'b1, 8'h19, 0, 5,  0,  16'h4181, 1'b0, 8,  5'd19, 14'd4181};
        vecs[8] = '{1'b0, 8'h21, 1, 1,  1,  16'h9999, 1'b0, 6,  5'd21, 14'd9999};

        repeat (3) @(negedge clk);
        chk("rst_ctrl", {req_ack, b2b_start, fib_start, b2d_start, rsp_valid, rsp_id, rsp_err, busy}, 0);
        chk("rst_rsp_bcd", rsp_bcd, 0);
        chk("rst_operands", {b2b_bcd, fib_idx, b2d_bin}, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_busy", busy, 0);

        foreach (vecs[i]) begin
            run_job(vecs[i].id, vecs[i].bcd, vecs[i].tb, vecs[i].tf, vecs[i].td,
                    vecs[i].ebcd, vecs[i].eerr, vecs[i].elat, $sformatf("vec%0d", i));
            if (!vecs[i].eerr) begin
                chk($sformatf("vec%0d_fib_idx", i), seen_idx, vecs[i].eidx);
                chk($sformatf("vec%0d_b2d_bin", i), seen_bin, vecs[i].ebin);
            end
        end

        // One requester held: back-to-back grants separated by a single IDLE cycle.
        t_b2b = 1; t_fib = 1; t_b2d = 1;
        push_exp(1'b1, 16'h0003, 1'b0);
        push_exp(1'b1, 16'h0003, 1'b0);
        @(negedge clk);
        req_bcd1 = 8'h04; req_valid = 2'b10;
        wait_ack(50, got);
        chk("btb_ack1", req_ack, 2'b10);
        wait_rsp(100, n);
        gap = 0; got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk); gap++; got = (req_ack != 2'b00);
        end
        req_valid = 2'b00;
        chk("btb_gap", gap, 2);
        chk("btb_ack2", req_ack, 2'b10);
        wait_rsp(100, n);
        chk("btb_rsp2", rsp_valid, 1);
        rr_last = 1'b1;

        // Fib unit never answers: abort 16 cycles after fib_start.
        fib_hang = 1; t_b2b = 1;
        push_exp(1'b0, 16'h0000, 1'b1);
        @(negedge clk);
        req_bcd0 = 8'h07; req_valid = 2'b01;
        wait_ack(50, got);
        req_valid = 2'b00;
        chk("tmo_ack", req_ack, 2'b01);
        wait_rsp(100, n);
        chk("tmo_rsp", rsp_valid, 1);
        chk("tmo_gap", cyc - fib_start_cyc, 16);
        fib_hang = 0;

        // Late fib_done lands during the next job's B2B stage and must be ignored.
        fork
            run_job(1'b0, 8'h08, 5, 2, 2, 16'h0021, 1'b0, 12, "late");
            begin
                repeat (3) @(negedge clk);
                fib_late = 1;
                @(negedge clk);
                fib_late = 0;
            end
        join

        // Reset pulse during FIB: job vanishes with no response.
        t_b2b = 1; t_fib = 10; t_b2d = 1;
        push_exp(1'b0, 16'h0055, 1'b0);
        @(negedge clk);
        req_bcd0 = 8'h10; req_valid = 2'b01;
        wait_ack(50, got);
        req_valid = 2'b00;
        for (int i = 0; i < 50 && !fib_start; i++) @(negedge clk);
        chk("rst_fib_started", fib_start, 1);
        @(negedge clk);
        n0 = n_start;
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        void'(exp_q.pop_back());
        rr_last = 1'b1;
        @(negedge clk);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_rsp", rsp_valid, 0);
        repeat (30) @(negedge clk);
        chk("rst_mid_idle", busy, 0);
        chk("rst_mid_starts", n_start - n0, 0);

        // Stray b2d_done pulses while idle.
        n0 = n_start;
        for (int k = 0; k < 3; k++) begin
            b2d_stray = 1;
            @(negedge clk);
            b2d_stray = 0;
            chk("stray_busy", busy, 0);
        end
        chk("stray_starts", n_start - n0, 0);

        // Both requesters held for four jobs: grants alternate, starting after rr_last.
        t_b2b = 1; t_fib = 1; t_b2d = 1;
        for (int k = 0; k < 4; k++) begin
            g = (~rr_last) ^ k[0];
            push_exp(g, g ? 16'h0008 : 16'h0005, 1'b0);
        end
        @(negedge clk);
        req_bcd0 = 8'h05; req_bcd1 = 8'h06; req_valid = 2'b11;
        g = ~rr_last;
        for (int k = 0; k < 4; k++) begin
            wait_ack(100, got);
            chk($sformatf("alt_ack%0d", k), req_ack, g ? 2'b10 : 2'b01);
            if (k == 3) req_valid = 2'b00;
            else g = ~g;
        end
        rr_last = g;
        wait_rsp(100, n);
        chk("alt_last_rsp", rsp_valid, 1);
        repeat (5) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fibo_job_scheduler.md
# fibo_job_scheduler

Sequencing and arbitration controller for the Fibonacci display pipeline. It accepts jobs from two requesters, for example the debounced switch/button path and a command interface. Each job carries a two-digit BCD index. The scheduler grants one job at a time, round-robin, and walks it through three shared compute units: BCD-to-binary, Fibonacci iteration, and binary-to-BCD. Each unit uses a start/done handshake. The block returns a 4-digit BCD result, tagged with the requester id, to the display/response logic.

## Interface
Parameters:
- TIMEOUT_CYC, default 1024: maximum cycles to wait for any stage done before aborting the job.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- req_valid  in  2  per-requester job request; held until accepted.
- req_bcd0, req_bcd1  in  8 each  requester 0/1 operand {tens, ones} BCD.
- req_ack  out  2  one-cycle pulse on the bit of the accepted requester.
- b2b_start  out  1  start pulse to BCD-to-binary unit.
- b2b_bcd  out  8  its operand.
- b2b_done  in  1  done pulse.
- b2b_bin  in  7  its result.
- fib_start  out  1  start pulse to Fibonacci unit.
- fib_idx  out  5  its index.
- fib_done  in  1  done pulse.
- fib_val  in  20  its result.
- b2d_start  out  1  start pulse to binary-to-BCD unit.
- b2d_bin  out  14  its operand.
- b2d_done  in  1  done pulse.
- b2d_bcd  in  16  its result.
- rsp_valid  out  1  one-cycle result pulse.
- rsp_id  out  1  requester of the result.
- rsp_bcd  out  16  4-digit BCD result.
- rsp_err  out  1  qualifies rsp_valid: invalid digit or timeout.
- busy  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, B2B, FIB, B2D, RESP.
- IDLE: if any req_valid is set, grant round-robin.
  - Priority goes to the requester not granted last.
  - The last-grant pointer resets to 1, so requester 0 wins first.
  - The granted operand is latched, req_ack pulses, and rsp_id is latched.
- Operand check: a latched digit above 9 goes straight to RESP with rsp_err=1 and rsp_bcd=0. No stage is started.
- B2B: pulse b2b_start in the first cycle of the state. Wait for b2b_done.
  - Saturate the result: fib_idx = (b2b_bin > 31) ? 31 : b2b_bin[4:0].
  - Then go to FIB.
- FIB: pulse fib_start and wait for fib_done.
  - Saturate the result: b2d_bin = (fib_val >= 9999) ? 9999 : fib_val[13:0].
  - Then go to B2D.
- B2D: pulse b2d_start and wait for b2d_done.
  - Latch b2d_bcd into rsp_bcd with rsp_err=0.
  - Then go to RESP.
- RESP: rsp_valid=1 for one cycle. Advance the round-robin pointer, then return to IDLE.
- Timeout: a single 11-bit (clog2) stage counter clears on every stage entry.
  - If it reaches TIMEOUT_CYC-1 without done, go to RESP with rsp_err=1 and rsp_bcd=0.
  - A late done from the aborted unit is ignored. Done inputs are only sampled in the matching state.
- Stray done pulses in IDLE or in a non-matching state are ignored.
- req_valid changes during a job have no effect. Arbitration happens only in IDLE.
- Reset values: state IDLE, all outputs 0 (req_ack, starts, rsp_*, busy), operand/result registers 0.
- Reset mid-job aborts the job with no response. Compute units share rst_n.

## Timing
- Grant: req_valid seen in IDLE at cycle N gives req_ack and the B2B entry at N+1, and b2b_start at N+1.
- Each start is a registered single-cycle pulse on the state-entry cycle.
- A done at cycle M moves to the next state at M+1, where that stage's start pulses.
- A done arriving in the same cycle as its start (zero-latency unit) is accepted.
- RESP lasts exactly one cycle. IDLE re-arbitrates the following cycle, so the minimum job-to-job gap is one IDLE cycle.
- Latency = 3 + t_b2b + t_fib + t_b2d cycles from accept to rsp_valid.
- Operand outputs (b2b_bcd, fib_idx, b2d_bin) are registered and stable from start until done.

## Structure
- Shared package fibo_pkg:
  - state enum sched_state_t.
  - Constants FIB_IDX_MAX=31 and BCD_SAT=9999.
  - BCD digit width.
- One sub-module, rr_arbiter2: 2-way round-robin with pointer update on an advance strobe.
- Everything else is a single next-state always_comb plus a register always_ff.

## Test plan
- Requester 0 sends 0x07 with 2/10/15-cycle stage models -> req_ack=01, rsp_bcd=0x0013, rsp_err=0, latency 30 cycles.
- 0x20 -> 0x6765. 0x25 -> fib_idx=25, fib_val=75025 saturates to b2d_bin=9999 -> rsp_bcd=0x9999. 0x00 -> 0x0000.
- Both req_valid held for 4 jobs -> grants alternate 0,1,0,1 with matching rsp_id. One requester alone -> back-to-back grants.
- Operand 0x1A -> rsp_err=1, rsp_bcd=0, no *_start pulses.
- fib unit never responds, TIMEOUT_CYC=16 -> rsp_err=1 exactly 16 cycles after fib_start. A late fib_done is then ignored and the next job completes normally.
- rst_n low for 1 cycle during FIB -> busy=0 and no rsp_valid. Stray b2d_done pulses in IDLE -> no state change.
